// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - queues host I2C commands and issues them to the i2c master one at a time
module i2c_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [6:0]               cmd_addr,
    input  logic [7:0]               cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic [6:0]               m_addr,
    output logic [7:0]               m_data_in,
    output logic                     m_rw,
    output logic                     m_enable,
    input  logic [7:0]               m_data_out,
    input  logic                     m_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_timeout,
    input  logic                     err_clr
);
    localparam int CW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW:0] TLIM = (TW+1)'(TIMEOUT - 1);
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, ACCEPT, BUSY, DONE} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW:0]   count_next;
    logic [TW:0]   timer;
    logic          push;
    logic          pop;

    // A read may not overwrite a response the host has not yet taken.
    assign push = cmd_valid && cmd_ready;
    assign pop  = (state == IDLE) && (count != '0) && m_ready &&
                  !(mem[rd_ptr][15] && rsp_valid);
    assign busy = (state != IDLE) || (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            cmd_ready <= (count_next != FULL);
        end
    end

    // The popped entry sits just behind rd_ptr while in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_addr      <= '0;
            m_data_in   <= '0;
            m_rw        <= 1'b0;
            m_enable    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            err_timeout <= 1'b0;
            timer       <= '0;
        end else begin
            if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;
            if (err_clr)
                err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop)
                        state <= LOAD;
                end
                LOAD: begin
                    {m_rw, m_addr, m_data_in} <= mem[rd_ptr - CW'(1)];
                    timer    <= '0;
                    m_enable <= 1'b1;
                    state    <= ACCEPT;
                end
                ACCEPT: begin
                    timer <= timer + 1'b1;
                    if (timer == TLIM) begin
                        m_enable    <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (!m_ready) begin
                        m_enable <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    timer <= timer + 1'b1;
                    if (timer == TLIM) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (m_ready) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (m_rw) begin
                        rsp_data  <= m_data_out;
                        rsp_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Upstream feeder for the i2c master. It queues host I2C transactions ({rw, 7-bit addr, 8-bit data}) in a small FIFO and issues them one at a time over the master's addr/data_in/rw/enable/ready handshake. For reads it captures the master's data_out into a response register with a valid/ready handshake. It adds a per-transaction timeout and a sticky error flag.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TIMEOUT, 1024, max clk cycles allowed in ACCEPT or BUSY before abort; must be greater than 1.
CW, $clog2(DEPTH), FIFO pointer width (derived, not overridable).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  host command offered
cmd_ready  output  1  FIFO can accept (not full)
cmd_rw  input  1  1 = read, 0 = write
cmd_addr  input  7  I2C slave address
cmd_data  input  8  write data; ignored for reads
rsp_valid  output  1  read data available
rsp_ready  input  1  host consumes response
rsp_data  output  8  captured read byte
m_addr  output  7  to master addr
m_data_in  output  8  to master data_in
m_rw  output  1  to master rw
m_enable  output  1  to master enable
m_data_out  input  8  from master data_out
m_ready  input  1  from master ready (1 = idle)
busy  output  1  state != IDLE or FIFO not empty
count  output  CW+1  FIFO occupancy, 0..DEPTH
err_timeout  output  1  sticky timeout flag
err_clr  input  1  clears err_timeout

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count = 0, state = IDLE, cmd_ready = 1, rsp_valid = 0, rsp_data = 0, m_enable = 0, m_addr/m_data_in/m_rw = 0, err_timeout = 0, timer = 0. Reset mid-transaction drops the current and all queued commands. Nothing is replayed.
- FIFO push: on cmd_valid && cmd_ready. cmd_ready = (count != DEPTH). Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count is unchanged. When full, a push in the same cycle as a pop is still refused, because cmd_ready is registered from count.
- Pop occurs only on the IDLE->LOAD transition.
- IDLE: if count != 0 and m_ready = 1, and the head is not (read while rsp_valid = 1), pop the head and go to LOAD. Otherwise stay. This stalls a read behind an unconsumed response; writes are not stalled by a pending response.
- LOAD (1 cycle): register the head into m_addr/m_data_in/m_rw. Clear the timer. Go to ACCEPT.
- ACCEPT: m_enable = 1, with m_addr/m_data_in/m_rw stable. When m_ready = 0 is sampled, deassert m_enable the next cycle and go to BUSY.
- BUSY: m_enable = 0. When m_ready = 1 is sampled, go to DONE.
- DONE (1 cycle): if m_rw = 1, rsp_data <= m_data_out and rsp_valid <= 1. Go to IDLE.
- m_addr/m_data_in/m_rw hold their last values in IDLE.
- Timeout: the timer increments each cycle in ACCEPT or BUSY. When it reaches TIMEOUT-1: m_enable <= 0, err_timeout <= 1, go to IDLE. The command is discarded and no response is produced.
- Response handshake: rsp_valid clears on rsp_valid && rsp_ready. If a DONE write of rsp_valid coincides with consumption, the set wins.
- err_timeout: err_clr clears it. If a set and err_clr occur in the same cycle, the set wins.
- Latency: a command pushed into an empty FIFO with m_ready = 1 gives push at edge N, pop/LOAD at N+1, m_enable high from N+2.
- rsp_valid rises 2 cycles after the m_ready 0->1 edge: BUSY samples it, DONE registers it.

Test Plan:
1. Reset: hold rst_n = 0 for 5 cycles with cmd_valid = 1 -> count = 0, cmd_ready = 1, m_enable = 0, rsp_valid = 0, err_timeout = 0. The FIFO stays empty after release until a new push.
2. Single write: push {rw=0, addr=7'h2A, data=8'hAA} with the master model ready -> m_addr = 2A, m_data_in = AA, m_rw = 0, m_enable high until m_ready falls. No rsp_valid after completion. busy returns to 0.
3. Read: push {rw=1, addr=7'h50}; the master model returns data_out = 8'h5C -> rsp_valid = 1 with rsp_data = 5C two cycles after m_ready rises, held until rsp_ready.
4. Back-pressure: fill 4 writes with the master stalled (m_ready = 0) -> count = 4, cmd_ready = 0, and a fifth push is refused. Release m_ready -> all 4 issue in push order, count decrements to 0.
5. Read stall: push read A (8'h11), read B (8'h22) with rsp_ready = 0 -> B is not issued until A is consumed. Then rsp_data = 22.
6. Timeout: the master never drops m_ready after enable, with TIMEOUT = 16 -> m_enable drops after 16 cycles in ACCEPT, err_timeout = 1, and the next queued command issues. err_clr = 1 clears the flag.
